// File: rtl/seq_serializer_if.sv
// Handshake and serial-stream bundle for seq_serializer.
// The source side (master) presents words and the hold request; the serializer
// (slave) returns the ready flag and the serial stream.
//
// Handshake: a word transfers on a rising edge where load_valid=1 and
// load_ready=1. The source keeps load_data stable while load_valid=1 and the
// word has not yet transferred. load_valid seen while load_ready=0 has no effect.
interface seq_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             hold;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_last;
  logic             busy;
  logic             dbg_state;  // FSM state: 0 = IDLE, 1 = SHIFT

  modport master (
    output load_data, load_valid, hold,
    input  load_ready, ser_out, ser_valid, frame_last, busy, dbg_state
  );

  modport slave (
    input  load_data, load_valid, hold,
    output load_ready, ser_out, ser_valid, frame_last, busy, dbg_state
  );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter with one-cycle latency, hold stall and
// gapless back-to-back words. Bit order is chosen by MSB_FIRST.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           arst,
  seq_serializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;

  logic w_advance;
  logic w_last;
  logic w_ready;
  logic w_accept;
  logic w_head;

  // A bit is consumed on every non-held edge in SHIFT; the counter holds the
  // number of bits still to present, so count 1 marks the final bit.
  assign w_advance = (r_state == S_SHIFT) && !bus.hold;
  assign w_last    = w_advance && (r_cnt == CW'(1));
  // Ready on the final bit lets the next word load on the same edge that
  // retires the current one, so consecutive words run without a gap.
  assign w_ready   = (r_state == S_IDLE) || w_last;
  assign w_accept  = bus.load_valid && w_ready;
  // The bit currently presented always sits at the outgoing end of the shifter.
  assign w_head    = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

  // Shift one position toward the outgoing end, zero-filling behind.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return {v[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, v[WIDTH-1:1]};
    end
  endfunction

  // FSM: load on accept, advance when not held, return to IDLE after the last bit.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= S_SHIFT;
      r_shift <= bus.load_data;
      r_cnt   <= CW'(WIDTH);
    end else if (w_last) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_advance) begin
      r_shift <= shift_once(r_shift);
      r_cnt   <= r_cnt - CW'(1);
    end
  end

  // Outputs come straight from state registers; only the valid/last/ready
  // qualifiers also look at hold, because a stall must suppress them in the
  // same cycle. ser_out is the shifter head, so it stays frozen during hold.
  assign bus.ser_out    = (r_state == S_SHIFT) ? w_head : 1'b0;
  assign bus.ser_valid  = w_advance;
  assign bus.frame_last = w_last;
  assign bus.busy       = (r_state == S_SHIFT);
  assign bus.load_ready = w_ready;
  assign bus.dbg_state  = r_state;

endmodule
